input_pipeline_ctrl: RTL and testbench

INPUT_PIPELINE_CTRL -- requirements
Module: input_pipeline_ctrl

---
 rtl/input_pipeline_ctrl.sv | 97 +++++++++
 tb/tb_input_pipeline_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_pipeline_ctrl.sv
// Streams producer words through an external 1R1W SRAM used as a circular FIFO.
// A 2-entry output buffer absorbs the one-cycle SRAM read latency.
module input_pipeline_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              WE,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] WriteBus,
    output logic [ADDR_W-1:0] ReadAddress,
    input  logic [DATA_W-1:0] ReadBus,
    output logic [ADDR_W:0]   mem_count,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_mem_count;
    logic              r_rd_pend;
    logic [1:0]        r_buf_cnt;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;

    logic       w_push;
    logic       w_pop;
    logic       w_issue;
    logic [1:0] w_after_pop;
    logic [1:0] w_committed;

    assign full      = (r_mem_count == DEPTH);
    assign empty     = (r_mem_count == '0);
    assign in_ready  = ~full;
    assign out_valid = (r_buf_cnt != 2'd0);
    assign out_data  = r_buf0;

    // Reset wins over both handshakes, so nothing is written or popped that cycle.
    assign w_push      = in_valid & in_ready & ~reset;
    assign w_pop       = out_valid & out_ready & ~reset;
    assign w_after_pop = r_buf_cnt - {1'b0, w_pop};
    assign w_committed = w_after_pop + {1'b0, r_rd_pend};
    assign w_issue     = ~empty & (w_committed < 2'd2);

    assign WE           = w_push;
    assign WriteAddress = r_wptr;
    assign WriteBus     = in_data;
    assign ReadAddress  = r_rptr;
    assign mem_count    = r_mem_count;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_mem_count <= '0;
            r_rd_pend   <= 1'b0;
            r_buf_cnt   <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_mem_count <= r_mem_count + (ADDR_W+1)'(1);
                2'b01:   r_mem_count <= r_mem_count - (ADDR_W+1)'(1);
                default: r_mem_count <= r_mem_count;
            endcase
            r_rd_pend <= w_issue;
            r_buf_cnt <= w_committed;
        end
    end

    // NOTE: payload registers carry no reset; out_valid alone qualifies them.
    always_ff @(posedge clock) begin
        if (w_pop && r_buf_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
        end
        if (r_rd_pend) begin
            if (w_after_pop == 2'd0) begin
                r_buf0 <= ReadBus;
            end else begin
                r_buf1 <= ReadBus;
            end
        end
    end
endmodule

// File: tb/tb_input_pipeline_ctrl.sv
// Self-checking bench for input_pipeline_ctrl with a behavioural SRAM and a
// queue-based reference model of the FIFO, read path and output buffer.
module tb_input_pipeline_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          WE;
    logic [AW-1:0] WriteAddress;
    logic [DW-1:0] WriteBus;
    logic [AW-1:0] ReadAddress;
    logic [DW-1:0] ReadBus;
    logic [AW:0]   mem_count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words stored in SRAM, one in-flight read, buffered words.
    logic [DW-1:0] m_mem[$];
    logic [DW-1:0] m_buf[$];
    bit            m_inf;
    logic [DW-1:0] m_inf_d;
    int            m_wcnt;
    int            m_rcnt;

    bit            e_full, e_push, e_pop, e_ov, e_issue;
    logic [DW-1:0] e_od;
    logic [AW-1:0] e_wa, e_ra;
    logic [AW:0]   e_mc;

    logic [DW-1:0] sram [DEPTH];

    input_pipeline_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .WE(WE), .WriteAddress(WriteAddress), .WriteBus(WriteBus),
        .ReadAddress(ReadAddress), .ReadBus(ReadBus),
        .mem_count(mem_count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (WE) sram[WriteAddress] <= WriteBus;
        ReadBus <= sram[ReadAddress];
    end

    task automatic model_clear();
        m_mem.delete();
        m_buf.delete();
        m_inf  = 1'b0;
        m_wcnt = 0;
        m_rcnt = 0;
    endtask

    // Drive one cycle's inputs at the falling edge and derive expected outputs.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        e_full  = (m_mem.size() == DEPTH);
        e_push  = v && !e_full;
        e_ov    = (m_buf.size() != 0);
        e_od    = e_ov ? m_buf[0] : '0;
        e_pop   = e_ov && r;
        e_issue = (m_mem.size() != 0) && (int'(m_inf) + m_buf.size() - int'(e_pop) < 2);
        e_wa    = AW'(m_wcnt % DEPTH);
        e_ra    = AW'(m_rcnt % DEPTH);
        e_mc    = (AW+1)'(m_mem.size());
        #1;
    endtask

    task automatic advance();
        logic [DW-1:0] d;
        d = in_data;
        @(posedge clk);
        if (e_pop) void'(m_buf.pop_front());
        if (m_inf) m_buf.push_back(m_inf_d);
        m_inf = e_issue;
        if (e_issue) begin
            m_inf_d = m_mem.pop_front();
            m_rcnt++;
        end
        if (e_push) begin
            m_mem.push_back(d);
            m_wcnt++;
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
        drive(v, d, r);
        advance();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid act=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (WE !== 1'b0) $display("FAIL reset_we act=%b exp=0", WE); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty act=%b exp=1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full act=%b exp=0", full); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready act=%b exp=1", in_ready); else n_pass++;
        n_checks++; if (mem_count !== 5'd0) $display("FAIL reset_mem_count act=%0d exp=0", mem_count); else n_pass++;
        n_checks++; if (WriteAddress !== 4'd0) $display("FAIL reset_waddr act=%0d exp=0", WriteAddress); else n_pass++;
        n_checks++; if (ReadAddress !== 4'd0) $display("FAIL reset_raddr act=%0d exp=0", ReadAddress); else n_pass++;
    endtask

    task automatic test_single_word();
        drive(1'b1, 32'h1, 1'b1);
        n_checks++; if (WE !== 1'b1) $display("FAIL single_we act=%b exp=1", WE); else n_pass++;
        n_checks++; if (WriteAddress !== 4'd0) $display("FAIL single_waddr act=%0d exp=0", WriteAddress); else n_pass++;
        n_checks++; if (WriteBus !== 32'h1) $display("FAIL single_wbus act=%h exp=1", WriteBus); else n_pass++;
        advance();
        drive(1'b0, '0, 1'b1);
        n_checks++; if (ReadAddress !== 4'd0) $display("FAIL single_raddr act=%0d exp=0", ReadAddress); else n_pass++;
        n_checks++; if (mem_count !== 5'd1) $display("FAIL single_count act=%0d exp=1", mem_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early1 act=%b exp=0", out_valid); else n_pass++;
        advance();
        drive(1'b0, '0, 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early2 act=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (ReadAddress !== 4'd1) $display("FAIL single_rptr act=%0d exp=1", ReadAddress); else n_pass++;
        advance();
        drive(1'b0, '0, 1'b1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid act=%b exp=1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h1) $display("FAIL single_data act=%h exp=1", out_data); else n_pass++;
        advance();
        drive(1'b0, '0, 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drained act=%b exp=0", out_valid); else n_pass++;
        advance();
    endtask

    task automatic test_streaming();
        int got = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 130 && got < 100; c++) begin
            drive(c < 100, DW'(c + 1), 1'b1);
            n_checks++; if (WE !== e_push) $display("FAIL stream_we c=%0d act=%b exp=%b", c, WE, e_push); else n_pass++;
            if (out_valid === 1'b1) begin
                n_checks++; if (out_data !== DW'(got + 1)) $display("FAIL stream_data act=%0d exp=%0d", out_data, got + 1); else n_pass++;
                if (first < 0) first = c;
                last = c;
                got++;
            end
            advance();
        end
        n_checks++; if (got !== 100) $display("FAIL stream_count act=%0d exp=100", got); else n_pass++;
        n_checks++; if (first !== 3) $display("FAIL stream_latency act=%0d exp=3", first); else n_pass++;
        n_checks++; if (last - first !== 99) $display("FAIL stream_bubbles act=%0d exp=99", last - first); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] words [10];
        int got = 0;
        for (int i = 0; i < 10; i++) words[i] = DW'($urandom);
        for (int i = 0; i < 10; i++) step(1'b1, words[i], 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid act=%b exp=1", out_valid); else n_pass++;
            n_checks++; if (out_data !== words[0]) $display("FAIL bp_hold act=%h exp=%h", out_data, words[0]); else n_pass++;
            n_checks++; if (mem_count !== 5'd8) $display("FAIL bp_count act=%0d exp=8", mem_count); else n_pass++;
            advance();
        end
        for (int c = 0; c < 40 && got < 10; c++) begin
            drive(1'b0, '0, 1'b1);
            if (out_valid === 1'b1) begin
                n_checks++; if (out_data !== words[got]) $display("FAIL bp_order i=%0d act=%h exp=%h", got, out_data, words[got]); else n_pass++;
                got++;
            end
            advance();
        end
        n_checks++; if (got !== 10) $display("FAIL bp_drain act=%0d exp=10", got); else n_pass++;
    endtask

    // A stalled controller holds 16 words in SRAM plus two in the read path
    // (in-flight read + buffer never exceed two without a pop).
    task automatic test_full_wrap();
        int got = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(32'h100 + i), 1'b0);
            n_checks++; if (WE !== (i < 18)) $display("FAIL full_we i=%0d act=%b exp=%b", i, WE, i < 18); else n_pass++;
            if (i < 18) begin
                n_checks++; if (WriteAddress !== AW'(i % 16)) $display("FAIL full_waddr i=%0d act=%0d exp=%0d", i, WriteAddress, i % 16); else n_pass++;
            end
            advance();
        end
        drive(1'b0, '0, 1'b0);
        n_checks++; if (full !== 1'b1) $display("FAIL full_flag act=%b exp=1", full); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready act=%b exp=0", in_ready); else n_pass++;
        n_checks++; if (mem_count !== 5'd16) $display("FAIL full_count act=%0d exp=16", mem_count); else n_pass++;
        advance();
        for (int c = 0; c < 60 && got < 18; c++) begin
            drive(1'b0, '0, 1'b1);
            if (out_valid === 1'b1) begin
                n_checks++; if (out_data !== DW'(32'h100 + got)) $display("FAIL full_order i=%0d act=%h exp=%h", got, out_data, 32'h100 + got); else n_pass++;
                got++;
            end
            advance();
        end
        n_checks++; if (got !== 18) $display("FAIL full_drain act=%0d exp=18", got); else n_pass++;
        for (int i = 0; i < 26; i++) begin
            drive(i < 20, DW'(32'h200 + i), 1'b1);
            if (i < 20) begin
                n_checks++; if (WriteAddress !== AW'((2 + i) % 16)) $display("FAIL wrap_waddr i=%0d act=%0d exp=%0d", i, WriteAddress, (2 + i) % 16); else n_pass++;
            end
            n_checks++; if (out_valid !== e_ov) $display("FAIL wrap_valid act=%b exp=%b", out_valid, e_ov); else n_pass++;
            if (e_ov) begin
                n_checks++; if (out_data !== e_od) $display("FAIL wrap_data act=%h exp=%h", out_data, e_od); else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 7; i++) step(1'b1, DW'(32'h300 + i), 1'b0);
        drive(1'b0, '0, 1'b0);
        n_checks++; if (mem_count !== 5'd5) $display("FAIL sim_pre_count act=%0d exp=5", mem_count); else n_pass++;
        advance();
        drive(1'b1, 32'h307, 1'b1);
        n_checks++; if (WE !== 1'b1) $display("FAIL sim_we act=%b exp=1", WE); else n_pass++;
        n_checks++; if (WriteAddress !== 4'd7) $display("FAIL sim_waddr act=%0d exp=7", WriteAddress); else n_pass++;
        n_checks++; if (ReadAddress !== 4'd2) $display("FAIL sim_raddr act=%0d exp=2", ReadAddress); else n_pass++;
        n_checks++; if (out_data !== 32'h300) $display("FAIL sim_head act=%h exp=300", out_data); else n_pass++;
        advance();
        drive(1'b0, '0, 1'b0);
        n_checks++; if (mem_count !== 5'd5) $display("FAIL sim_count act=%0d exp=5", mem_count); else n_pass++;
        n_checks++; if (WriteAddress !== 4'd8) $display("FAIL sim_wptr act=%0d exp=8", WriteAddress); else n_pass++;
        n_checks++; if (ReadAddress !== 4'd3) $display("FAIL sim_rptr act=%0d exp=3", ReadAddress); else n_pass++;
        advance();
    endtask

    task automatic test_mid_reset();
        step(1'b1, 32'h308, 1'b0);
        step(1'b1, 32'h309, 1'b0);
        drive(1'b0, '0, 1'b0);
        n_checks++; if (mem_count !== 5'd7) $display("FAIL mid_pre_count act=%0d exp=7", mem_count); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid act=%b exp=1", out_valid); else n_pass++;
        advance();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
        #1;
        n_checks++; if (WE !== 1'b0) $display("FAIL mid_we_in_reset act=%b exp=0", WE); else n_pass++;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid act=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (mem_count !== 5'd0) $display("FAIL mid_count act=%0d exp=0", mem_count); else n_pass++;
        n_checks++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_flags act=%b%b%b exp=101", empty, full, in_ready); else n_pass++;
        n_checks++; if (ReadAddress !== 4'd0) $display("FAIL mid_raddr act=%0d exp=0", ReadAddress); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_discard act=%b exp=0", out_valid); else n_pass++;
            advance();
        end
        drive(1'b1, 32'hABC, 1'b1);
        n_checks++; if (WE !== 1'b1 || WriteAddress !== 4'd0) $display("FAIL mid_push act=%b/%0d exp=1/0", WE, WriteAddress); else n_pass++;
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, '0, 1'b1);
            n_checks++; if (out_valid !== e_ov) $display("FAIL mid_out_valid act=%b exp=%b", out_valid, e_ov); else n_pass++;
            if (e_ov) begin
                n_checks++; if (out_data !== 32'hABC) $display("FAIL mid_out_data act=%h exp=abc", out_data); else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit v, r;
        apply_reset();
        for (int c = 0; c < 900; c++) begin
            case (c / 300)
                0:       begin v = ($urandom_range(0, 7) != 0); r = ($urandom_range(0, 3) == 0); end
                1:       begin v = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 7) != 0); end
                default: begin v = ($urandom_range(0, 1) != 0); r = ($urandom_range(0, 1) != 0); end
            endcase
            drive(v, DW'($urandom), r);
            n_checks++; if (in_ready !== !e_full) $display("FAIL rand_in_ready c=%0d act=%b exp=%b", c, in_ready, !e_full); else n_pass++;
            n_checks++; if (WE !== e_push) $display("FAIL rand_we c=%0d act=%b exp=%b", c, WE, e_push); else n_pass++;
            if (e_push) begin
                n_checks++; if (WriteAddress !== e_wa) $display("FAIL rand_waddr c=%0d act=%0d exp=%0d", c, WriteAddress, e_wa); else n_pass++;
            end
            n_checks++; if (ReadAddress !== e_ra) $display("FAIL rand_raddr c=%0d act=%0d exp=%0d", c, ReadAddress, e_ra); else n_pass++;
            n_checks++; if (mem_count !== e_mc) $display("FAIL rand_count c=%0d act=%0d exp=%0d", c, mem_count, e_mc); else n_pass++;
            n_checks++; if (out_valid !== e_ov) $display("FAIL rand_valid c=%0d act=%b exp=%b", c, out_valid, e_ov); else n_pass++;
            if (e_ov) begin
                n_checks++; if (out_data !== e_od) $display("FAIL rand_data c=%0d act=%h exp=%h", c, out_data, e_od); else n_pass++;
            end
            advance();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_full_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
